gmii_rx_deframer: RTL and testbench
===================================

GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- MIN_FRAME, 64, minimum legal frame length in bytes (DA through FCS).
- MAX_FRAME, 1518, maximum legal frame length in bytes.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- lclk  in  1  single clock, 125 MHz.
- rst  in  1  asynchronous, active-high reset.
- gmii_rxd  in  8  GMII receive byte.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- rx_full  in  1  downstream has fewer than 190 free 64-bit words.
- rx_wr  out  1  one-cycle word write strobe.
- rx_data  out  64  packed bytes; first byte in [7:0].
- rx_keep  out  8  byte-valid mask; bit i covers byte lane i.
- rx_last  out  1  word is the frame's final word.
- rx_err  out  1  frame bad; valid only with rx_last.
- frame_cnt  out  16  good frames, saturating.
- err_cnt  out  16  frames ended with rx_err=1, saturating.
- drop_cnt  out  16  frames discarded with no write, saturating.
REQ-003 SHALL have one clock and an asynchronous active-high reset.

Function
REQ-004 SHALL use FSM states IDLE, PRE, DATA, DROP.
REQ-005 IDLE SHALL move to PRE on dv=1 & rxd=0x55, and to DROP on dv=1 with any other byte.
REQ-006 PRE SHALL stay on 0x55 and return to IDLE on dv=0 with no count change.
REQ-007 PRE SHALL, on 0xD5, go to DATA when rx_full=0, else to DROP with drop_cnt+1.
REQ-008 PRE SHALL, on any other byte, go to DROP with drop_cnt+1.
REQ-009 DATA SHALL pack bytes into lanes 0..7 in order and feed every byte, FCS included, to CRC-32.
- CRC-32 is reflected, poly 0xEDB88320, init 0xFFFFFFFF.
REQ-010 A completed 8-byte word SHALL be held and written (rx_wr=1, keep=0xFF, last=0) on the edge after the next frame byte is sampled.
REQ-011 On the first sampled dv=0 in DATA, the held or partial word SHALL be written on the next edge with rx_last=1 and rx_keep = the contiguous low mask of valid bytes; the FSM then goes to IDLE.
REQ-012 rx_err SHALL be 1 on the last word if any of the following holds:
- gmii_rx_er was seen in DATA;
- length < MIN_FRAME;
- CRC register ≠ 0xDEBB20E3.
REQ-013 On sampling byte MAX_FRAME+1, the current word SHALL be written including that byte, with rx_last=1 and rx_err=1; the FSM then goes to DROP.
REQ-014 DROP SHALL ignore input until dv=0, then go to IDLE; no writes occur in DROP.
REQ-015 Every frame that reaches DATA SHALL produce exactly one rx_last write.
- frame_cnt increments on the last write when rx_err=0; err_cnt increments when rx_err=1.
- All counters saturate at 0xFFFF.
REQ-016 The length counter SHALL be 11 bits and saturate at 2047.
REQ-017 rx_full SHALL be sampled only at SFD; writes are never stalled or suppressed mid-frame.
REQ-018 dv=1 with rx_er=1 in IDLE or PRE SHALL send the FSM to DROP with drop_cnt+1.
REQ-019 Back-to-back frames separated by one dv=0 cycle SHALL both be received.

Reset
REQ-020 rst SHALL asynchronously force:
- the FSM to IDLE;
- rx_wr, rx_last, rx_err, rx_keep and rx_data to 0;
- all counters and the length counter to 0;
- the CRC register to 0xFFFFFFFF.
REQ-021 After rst deasserts, the FSM SHALL leave IDLE only after at least one cycle of dv=0 has been sampled (the "armed" flag), so a frame cut by reset is ignored.

Structure
REQ-022 Package lmac_gmii_pkg SHALL hold:
- the state enum;
- PREAMBLE=0x55, SFD=0xD5;
- CRC_INIT, CRC_POLY, CRC_RESIDUE;
- the default MIN_FRAME and MAX_FRAME.
REQ-023 The block SHALL have one sub-module, crc32_d8: combinational 8-bit-per-cycle CRC next-state.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- 7×0x55, 0xD5, 60 bytes 0x00..0x3B plus correct FCS -> 8 writes; last keep=0xFF, last=1, err=0; frame_cnt=1.
- 65-byte good frame -> 9 writes; last keep=0x01, err=0.
- 64-byte frame with FCS byte 0 inverted -> last err=1; err_cnt=1, frame_cnt=0.
- rx_full=1 at SFD -> no writes; drop_cnt=1; the next frame with rx_full=0 is received normally.
- 1519-byte frame -> 190th write has keep=0x7F, last=1, err=1; nothing more until dv=0.
- rst pulsed mid-frame with dv held high -> outputs 0 and no writes until dv=0; the following 64-byte frame gives frame_cnt=1.

Source files
------------

// File: rtl/lmac_gmii_pkg.sv
// Shared constants and types for the GMII receive path: FSM states,
// preamble/SFD codes, CRC-32 parameters and default frame-size limits.
package lmac_gmii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;

    // Reflected CRC-32; running the register over data plus FCS leaves the residue.
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam int DEF_MIN_FRAME = 64;
    localparam int DEF_MAX_FRAME = 1518;

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected CRC-32 register for one input byte,
// least significant bit first.
module crc32_d8
    import lmac_gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, packs frame bytes into 64-bit
// words, checks FCS, length and rx_er, and keeps saturating frame statistics.
module gmii_rx_deframer
    import lmac_gmii_pkg::*;
#(
    parameter int MIN_FRAME = DEF_MIN_FRAME,
    parameter int MAX_FRAME = DEF_MAX_FRAME
) (
    input  logic        lclk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic        rx_full,
    output logic        rx_wr,
    output logic [63:0] rx_data,
    output logic [7:0]  rx_keep,
    output logic        rx_last,
    output logic        rx_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L = 11'(MAX_FRAME);

    state_t      state;
    logic        armed;
    logic [63:0] wbuf;
    logic [3:0]  wcnt;
    logic [10:0] len;
    logic [31:0] crc;
    logic        er_seen;

    logic [31:0] crc_nxt;
    logic [63:0] wbuf_ins;
    logic [10:0] len_inc;
    logic        frame_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (gmii_rxd),
        .crc_out (crc_nxt)
    );

    // A full word (wcnt==8) is held until the next byte shows it is not the last one.
    always_comb begin
        wbuf_ins = wcnt[3] ? 64'd0 : wbuf;
        wbuf_ins[{wcnt[2:0], 3'b000} +: 8] = gmii_rxd;
    end

    assign len_inc   = (len == 11'h7FF) ? len : len + 11'd1;
    assign frame_bad = er_seen || (len < MIN_L) || (crc != CRC_RESIDUE);

    always_ff @(posedge lclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            wbuf      <= 64'd0;
            wcnt      <= 4'd0;
            len       <= 11'd0;
            crc       <= CRC_INIT;
            er_seen   <= 1'b0;
            rx_wr     <= 1'b0;
            rx_data   <= 64'd0;
            rx_keep   <= 8'd0;
            rx_last   <= 1'b0;
            rx_err    <= 1'b0;
            frame_cnt <= 16'd0;
            err_cnt   <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            rx_wr   <= 1'b0;
            rx_last <= 1'b0;
            rx_err  <= 1'b0;
            // A frame already in flight at reset release is skipped until the line idles.
            if (!gmii_rx_dv) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (armed && gmii_rx_dv) begin
                        if (gmii_rx_er) begin
                            state    <= DROP;
                            drop_cnt <= sat_inc(drop_cnt);
                        end else if (gmii_rxd == PREAMBLE) begin
                            state <= PRE;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                PRE: begin
                    if (!gmii_rx_dv) begin
                        state <= IDLE;
                    end else if (gmii_rx_er) begin
                        state    <= DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (gmii_rxd == SFD) begin
                        if (rx_full) begin
                            state    <= DROP;
                            drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            state   <= DATA;
                            crc     <= CRC_INIT;
                            len     <= 11'd0;
                            wcnt    <= 4'd0;
                            wbuf    <= 64'd0;
                            er_seen <= 1'b0;
                        end
                    end else if (gmii_rxd != PREAMBLE) begin
                        state    <= DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                end

                DATA: begin
                    if (gmii_rx_dv) begin
                        crc     <= crc_nxt;
                        len     <= len_inc;
                        er_seen <= er_seen | gmii_rx_er;
                        wbuf    <= wbuf_ins;
                        wcnt    <= wcnt[3] ? 4'd1 : wcnt + 4'd1;
                        if (len == MAX_L) begin
                            // Oversize: close the frame on the offending byte and discard the rest.
                            rx_wr   <= 1'b1;
                            rx_last <= 1'b1;
                            rx_err  <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                            state   <= DROP;
                            if (wcnt[3]) begin
                                rx_data <= wbuf;
                                rx_keep <= 8'hFF;
                            end else begin
                                rx_data <= wbuf_ins;
                                rx_keep <= keep_mask(wcnt + 4'd1);
                            end
                        end else if (wcnt[3]) begin
                            rx_wr   <= 1'b1;
                            rx_data <= wbuf;
                            rx_keep <= 8'hFF;
                        end
                    end else begin
                        rx_wr   <= 1'b1;
                        rx_last <= 1'b1;
                        rx_err  <= frame_bad;
                        rx_data <= wbuf;
                        rx_keep <= keep_mask(wcnt);
                        state   <= IDLE;
                        if (frame_bad) err_cnt   <= sat_inc(err_cnt);
                        else           frame_cnt <= sat_inc(frame_cnt);
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: frames are built with their FCS, the
// expected word stream is queued as each frame is sent, and a monitor checks every write.
module tb_gmii_rx_deframer;

    localparam int MAX_FRAME = 1518;

    logic        lclk = 1'b0;
    logic        rst;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        rx_full;
    logic        rx_wr;
    logic [63:0] rx_data;
    logic [7:0]  rx_keep;
    logic        rx_last;
    logic        rx_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        err;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];

    int total = 0;
    int bad   = 0;
    int exp_frame = 0;
    int exp_err   = 0;
    int exp_drop  = 0;

    gmii_rx_deframer dut (
        .lclk       (lclk),
        .rst        (rst),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .rx_full    (rx_full),
        .rx_wr      (rx_wr),
        .rx_data    (rx_data),
        .rx_keep    (rx_keep),
        .rx_last    (rx_last),
        .rx_err     (rx_err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #4 lclk = ~lclk;

    // Write monitor: every write must match the head of the expected queue.
    always @(negedge lclk) begin
        if (rx_wr === 1'b1) begin
            total++;
            assert (exp_q.size() > 0)
            else begin
                bad++;
                $error("FAIL unexpected_write observed data=%h keep=%h last=%b required=no write",
                       rx_data, rx_keep, rx_last);
            end
            if (exp_q.size() > 0) begin
                wr_t         e;
                logic [63:0] m;
                e = exp_q.pop_front();
                for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{e.keep[i]}};
                total++;
                assert ({rx_data & m, rx_keep, rx_last, rx_err} === {e.data, e.keep, e.last, e.err})
                else begin
                    bad++;
                    $error("FAIL write observed data=%h keep=%h last=%b err=%b required data=%h keep=%h last=%b err=%b",
                           rx_data & m, rx_keep, rx_last, rx_err, e.data, e.keep, e.last, e.err);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic build_payload(input int n, input int base);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(8'(base + i));
    endtask

    task automatic append_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (frame_q[i]) c = crc_byte(c, frame_q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frame_q.push_back(c[i*8 +: 8]);
    endtask

    // Queue the words the deframer should write for frame_q; err marks an expected bad frame.
    task automatic expect_frame(input logic err);
        int  n;
        int  words;
        bit  ovf;
        wr_t e;
        ovf   = frame_q.size() > MAX_FRAME;
        n     = ovf ? MAX_FRAME + 1 : frame_q.size();
        words = (n + 7) / 8;
        for (int w = 0; w < words; w++) begin
            e = '0;
            for (int i = 0; i < 8; i++) begin
                if (w*8 + i < n) begin
                    e.data[i*8 +: 8] = frame_q[w*8 + i];
                    e.keep[i]        = 1'b1;
                end
            end
            e.last = (w == words - 1);
            e.err  = e.last ? (err | ovf) : 1'b0;
            exp_q.push_back(e);
        end
        if (err || ovf) exp_err++;
        else            exp_frame++;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
        @(posedge lclk);
        #1;
    endtask

    task automatic send(input logic full, input int er_idx, input int ipg);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        rx_full = full;
        drive(1'b1, 8'hD5, 1'b0);
        rx_full = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) drive(1'b1, frame_q[i], i == er_idx);
        for (int i = 0; i < ipg; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain_and_count(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge lclk);
            n++;
        end
        @(negedge lclk);
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frame));
        check({tag, "_err_cnt"},   64'(err_cnt),   64'(exp_err));
        check({tag, "_drop_cnt"},  64'(drop_cnt),  64'(exp_drop));
    endtask

    initial begin
        rst        = 1'b1;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        rx_full    = 1'b0;
        @(posedge lclk);
        #1;
        check("rst_wr",   64'(rx_wr),   64'd0);
        check("rst_data", rx_data,      64'd0);
        check("rst_keep", 64'(rx_keep), 64'd0);
        check("rst_last", 64'(rx_last), 64'd0);
        check("rst_err",  64'(rx_err),  64'd0);
        check("rst_cnts", {16'd0, frame_cnt, err_cnt, drop_cnt}, 64'd0);
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);

        // 64-byte good frame: eight full words.
        build_payload(60, 0);
        append_fcs();
        expect_frame(1'b0);
        send(1'b0, -1, 4);
        drain_and_count("good64");

        // 65-byte good frame: ninth word carries one byte.
        build_payload(61, 8'h80);
        append_fcs();
        expect_frame(1'b0);
        send(1'b0, -1, 4);
        drain_and_count("good65");

        // Corrupted FCS byte 0.
        build_payload(60, 8'h10);
        append_fcs();
        frame_q[60] = frame_q[60] ^ 8'hFF;
        expect_frame(1'b1);
        send(1'b0, -1, 4);
        drain_and_count("badfcs");

        // Downstream full at SFD: dropped, then the next frame is received.
        build_payload(60, 8'h20);
        append_fcs();
        exp_drop++;
        send(1'b1, -1, 4);
        drain_and_count("full_drop");
        build_payload(60, 8'h30);
        append_fcs();
        expect_frame(1'b0);
        send(1'b0, -1, 4);
        drain_and_count("after_full");

        // Oversize frame: closed on byte 1519, remainder ignored.
        build_payload(1525, 8'h05);
        expect_frame(1'b0);
        send(1'b0, -1, 4);
        drain_and_count("oversize");

        // Runt with a valid FCS, then rx_er mid-frame.
        build_payload(16, 8'h44);
        append_fcs();
        expect_frame(1'b1);
        send(1'b0, -1, 4);
        drain_and_count("runt");
        build_payload(60, 8'h50);
        append_fcs();
        expect_frame(1'b1);
        send(1'b0, 10, 4);
        drain_and_count("rx_er");

        // Back-to-back frames with a single idle cycle between them.
        build_payload(60, 8'h60);
        append_fcs();
        expect_frame(1'b0);
        send(1'b0, -1, 1);
        build_payload(70, 8'h90);
        append_fcs();
        expect_frame(1'b0);
        send(1'b0, -1, 4);
        drain_and_count("b2b");

        // Bad byte in preamble, and rx_er in IDLE.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h12, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        exp_drop++;
        drive(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        exp_drop++;
        drain_and_count("pre_drops");

        // Reset mid-frame with dv held high: nothing is received until the line idles.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wr",   64'(rx_wr),   64'd0);
        check("midrst_data", rx_data,      64'd0);
        check("midrst_keep", 64'(rx_keep), 64'd0);
        check("midrst_cnts", {16'd0, frame_cnt, err_cnt, drop_cnt}, 64'd0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        rst = 1'b0;
        exp_frame = 0;
        exp_err   = 0;
        exp_drop  = 0;
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drain_and_count("post_rst_ignored");
        build_payload(60, 8'hA0);
        append_fcs();
        expect_frame(1'b0);
        send(1'b0, -1, 4);
        drain_and_count("post_rst_good");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
